// File: rtl/mc_control_if.sv
// Control bus between the multicycle control FSM (master) and the datapath (slave).
// illegal_instr exists only when MC_ILLEGAL_TRAP_EN is defined.
interface mc_control_if;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
    logic [1:0] imm_src;
    logic [3:0] state;
`ifdef MC_ILLEGAL_TRAP_EN
    logic       illegal_instr;
`endif

    modport master (
        input  opcode, zero, mem_ready,
`ifdef MC_ILLEGAL_TRAP_EN
        output illegal_instr,
`endif
        output pc_write, adr_src, ir_write, mem_write, reg_write,
        output alu_src_a, alu_src_b, result_src, alu_op, imm_src, state
    );

    modport slave (
        output opcode, zero, mem_ready,
`ifdef MC_ILLEGAL_TRAP_EN
        input  illegal_instr,
`endif
        input  pc_write, adr_src, ir_write, mem_write, reg_write,
        input  alu_src_a, alu_src_b, result_src, alu_op, imm_src, state
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle RISC-V control FSM with shared instruction/data memory and mem_ready stalls.
// Define MC_ILLEGAL_TRAP_EN to trap unknown opcodes in an ERROR state (illegal_instr output).
module mc_control_fsm (
    input  logic             clk,
    input  logic             reset,
    mc_control_if.master     bus
);

    localparam logic [6:0] OpLoad   = 7'd3;
    localparam logic [6:0] OpImm    = 7'd19;
    localparam logic [6:0] OpStore  = 7'd35;
    localparam logic [6:0] OpReg    = 7'd51;
    localparam logic [6:0] OpBranch = 7'd99;
    localparam logic [6:0] OpJal    = 7'd111;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StAluWb    = 4'd7,
        StExecI    = 4'd8,
        StJal      = 4'd9,
        StBeq      = 4'd10,
        StError    = 4'd11
    } state_t;

    state_t state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            case (state_q)
                StFetch:    if (bus.mem_ready) state_q <= StDecode;
                StDecode: begin
                    case (bus.opcode)
                        OpLoad, OpStore: state_q <= StMemAdr;
                        OpReg:           state_q <= StExecR;
                        OpImm:           state_q <= StExecI;
                        OpJal:           state_q <= StJal;
                        OpBranch:        state_q <= StBeq;
`ifdef MC_ILLEGAL_TRAP_EN
                        default:         state_q <= StError;
`else
                        // Unknown opcode behaves as a NOP; PC was already advanced in fetch.
                        default:         state_q <= StFetch;
`endif
                    endcase
                end
                StMemAdr:   state_q <= (bus.opcode == OpLoad) ? StMemRead : StMemWrite;
                StMemRead:  if (bus.mem_ready) state_q <= StMemWb;
                StMemWb:    state_q <= StFetch;
                StMemWrite: if (bus.mem_ready) state_q <= StFetch;
                StExecR:    state_q <= StAluWb;
                StAluWb:    state_q <= StFetch;
                StExecI:    state_q <= StAluWb;
                StJal:      state_q <= StAluWb;
                StBeq:      state_q <= StFetch;
`ifdef MC_ILLEGAL_TRAP_EN
                StError:    state_q <= StError;
`endif
                default:    state_q <= StFetch;
            endcase
        end
    end

    always_comb begin
        bus.pc_write   = 1'b0;
        bus.adr_src    = 1'b0;
        bus.ir_write   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.reg_write  = 1'b0;
        bus.alu_src_a  = 2'b00;
        bus.alu_src_b  = 2'b00;
        bus.result_src = 2'b00;
        bus.alu_op     = 2'b00;
        case (bus.opcode)
            OpStore:  bus.imm_src = 2'b01;
            OpBranch: bus.imm_src = 2'b10;
            OpJal:    bus.imm_src = 2'b11;
            default:  bus.imm_src = 2'b00;
        endcase
        case (state_q)
            StFetch: begin
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
                bus.ir_write   = bus.mem_ready;
                bus.pc_write   = bus.mem_ready;
            end
            StDecode: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b01;
            end
            StMemAdr: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
            end
            StMemRead:  bus.adr_src = 1'b1;
            StMemWb: begin
                bus.result_src = 2'b01;
                bus.reg_write  = 1'b1;
            end
            StMemWrite: begin
                bus.adr_src   = 1'b1;
                bus.mem_write = 1'b1;
            end
            StExecR: begin
                bus.alu_src_a = 2'b10;
                bus.alu_op    = 2'b10;
            end
            StAluWb:    bus.reg_write = 1'b1;
            StExecI: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                bus.alu_op    = 2'b10;
            end
            StJal: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                bus.pc_write  = 1'b1;
            end
            StBeq: begin
                bus.alu_src_a = 2'b10;
                bus.alu_op    = 2'b01;
                bus.pc_write  = bus.zero;
            end
            default: ;
        endcase
        // Reset forces FETCH, where mem_ready would otherwise leak into pc/ir write.
        if (reset) begin
            bus.pc_write  = 1'b0;
            bus.ir_write  = 1'b0;
            bus.mem_write = 1'b0;
            bus.reg_write = 1'b0;
        end
    end

    assign bus.state = state_q;
`ifdef MC_ILLEGAL_TRAP_EN
    assign bus.illegal_instr = (state_q == StError);
`endif

endmodule
